pipe_stage_skid_reg: RTL



---
 rtl/pipe_stage_skid_reg_if.sv | 26 ++
 rtl/pipe_stage_skid_reg.sv | 109 ++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg_if.sv
// rtl/pipe_stage_skid_reg_if.sv - handshake bundle between two pipeline stages
// Upstream (in_*) and downstream (out_*) sides of one skid-buffered stage register.
interface pipe_stage_skid_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    // master: the surrounding pipeline/hazard logic; slave: the stage register itself
    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - 2-entry skid pipeline stage register with flush-to-bubble
// Optional stall/flush statistics counters are built when PIPE_STATS_EN is defined.
module pipe_stage_skid_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    pipe_stage_skid_reg_if.slave bus
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    logic              mainValid, skidValid, inReadyQ;
    logic [CTRL_W-1:0] mainCtrl, skidCtrl;
    logic [DATA_W-1:0] mainData, skidData;

    logic              mainValidNext, skidValidNext;
    logic [CTRL_W-1:0] mainCtrlNext, skidCtrlNext;
    logic [DATA_W-1:0] mainDataNext, skidDataNext;

    logic inFire, outFire;

    assign inFire  = bus.in_valid & inReadyQ;
    assign outFire = mainValid & bus.out_ready;

    always_comb begin
        mainValidNext = mainValid;
        mainCtrlNext  = mainCtrl;
        mainDataNext  = mainData;
        skidValidNext = skidValid;
        skidCtrlNext  = skidCtrl;
        skidDataNext  = skidData;
        if (flush) begin
            // A beat leaving on this edge still counts as delivered; only stored beats die.
            mainValidNext = 1'b0;
            mainCtrlNext  = '0;
            mainDataNext  = '0;
            skidValidNext = 1'b0;
        end else if (!mainValid) begin
            if (inFire) begin
                mainValidNext = 1'b1;
                mainCtrlNext  = bus.in_ctrl;
                mainDataNext  = bus.in_data;
            end
        end else if (!skidValid) begin
            if (inFire && outFire) begin
                mainCtrlNext = bus.in_ctrl;
                mainDataNext = bus.in_data;
            end else if (inFire) begin
                skidValidNext = 1'b1;
                skidCtrlNext  = bus.in_ctrl;
                skidDataNext  = bus.in_data;
            end else if (outFire) begin
                mainValidNext = 1'b0;
            end
        end else if (outFire) begin
            mainCtrlNext  = skidCtrl;
            mainDataNext  = skidData;
            skidValidNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            mainCtrl  <= '0;
            mainData  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            skidData  <= '0;
            inReadyQ  <= 1'b0;
        end else begin
            mainValid <= mainValidNext;
            mainCtrl  <= mainCtrlNext;
            mainData  <= mainDataNext;
            skidValid <= skidValidNext;
            skidCtrl  <= skidCtrlNext;
            skidData  <= skidDataNext;
            inReadyQ  <= !skidValidNext;
        end
    end

    // Control is masked so an empty stage always presents a NOP bubble downstream.
    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = mainValid;
    assign bus.out_ctrl  = mainValid ? mainCtrl : '0;
    assign bus.out_data  = mainData;

`ifdef PIPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mainValid && !bus.out_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && (mainValid || skidValid) && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif
endmodule
